// File: rtl/c_rsample_up_if.sv
// AXI4-Stream video bus used on both sides of the chroma upsampler.
// W selects the tdata width (16 for 4:2:2 input, 24 for 4:4:4 output).
interface c_rsample_up_if #(
    parameter int unsigned W = 16
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tuser;
    logic         tlast;

    modport master (
        output tdata,
        output tvalid,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tuser,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/c_rsample_up.sv
// 4:2:2 -> 4:4:4 chroma upsampler: even pixel {Cb,Y} is held, the odd pixel {Cr,Y}
// completes the pair, and both output pixels carry the shared Cb/Cr.
module c_rsample_up #(
    parameter logic [7:0] NEUTRAL_CHROMA = 8'h80
) (
    input  logic           aclk,
    input  logic           aresetn,
    c_rsample_up_if.slave  s_axis_video,
    c_rsample_up_if.master m_axis_video,
    output logic           sync_err
);

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_t;

    par_t       r_par;
    par_t       w_par_nxt;

    logic [1:0] r_rst_sync;
    logic       w_run;

    // hold register: even pixel waiting for its odd partner
    logic [7:0] r_hold_y;
    logic [7:0] r_hold_cb;
    logic       r_hold_user;

    // pair buffer
    logic [7:0] r_y0;
    logic [7:0] r_y1;
    logic [7:0] r_cb;
    logic [7:0] r_cr;
    logic       r_user;
    logic       r_last;
    logic [1:0] r_cnt;
    logic       r_idx;
    logic       r_sync_err;

    logic [7:0] w_in_y;
    logic [7:0] w_in_c;
    logic       w_s_acc;
    logic       w_m_acc;
    logic       w_even;
    logic       w_buf_free;
    logic       w_tready;
    logic       w_ld_hold;
    logic       w_ld_pair;
    logic       w_ld_orphan;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    always_comb begin
        w_run       = r_rst_sync[1];
        w_in_y      = s_axis_video.tdata[7:0];
        w_in_c      = s_axis_video.tdata[15:8];
        w_m_acc     = (r_cnt != 2'd0) && m_axis_video.tready;
        w_buf_free  = (r_cnt == 2'd0) || ((r_cnt == 2'd1) && m_axis_video.tready);
        // an even non-last beat only needs the hold register, which is free at even parity
        w_tready    = w_run && (((r_par == PAR_EVEN) && !s_axis_video.tlast) || w_buf_free);
        w_s_acc     = s_axis_video.tvalid && w_tready;
        w_even      = (r_par == PAR_EVEN) || s_axis_video.tuser;
        w_ld_hold   = w_s_acc && w_even && !s_axis_video.tlast;
        w_ld_orphan = w_s_acc && w_even && s_axis_video.tlast;
        w_ld_pair   = w_s_acc && !w_even;
    end

    always_comb begin
        w_par_nxt = r_par;
        if (w_s_acc) begin
            if (s_axis_video.tlast) begin
                w_par_nxt = PAR_EVEN;
            end else if (s_axis_video.tuser) begin
                w_par_nxt = PAR_ODD;
            end else begin
                w_par_nxt = (r_par == PAR_EVEN) ? PAR_ODD : PAR_EVEN;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_par <= PAR_EVEN;
        end else begin
            r_par <= w_par_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_hold_y    <= '0;
            r_hold_cb   <= '0;
            r_hold_user <= 1'b0;
        end else if (w_ld_hold) begin
            r_hold_y    <= w_in_y;
            r_hold_cb   <= w_in_c;
            r_hold_user <= s_axis_video.tuser;
        end
    end

    // a new load may coincide with acceptance of the final pending beat (no bubble)
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_y0   <= '0;
            r_y1   <= '0;
            r_cb   <= '0;
            r_cr   <= '0;
            r_user <= 1'b0;
            r_last <= 1'b0;
            r_cnt  <= '0;
            r_idx  <= 1'b0;
        end else if (w_ld_pair) begin
            r_y0   <= r_hold_y;
            r_y1   <= w_in_y;
            r_cb   <= r_hold_cb;
            r_cr   <= w_in_c;
            r_user <= r_hold_user;
            r_last <= s_axis_video.tlast;
            r_cnt  <= 2'd2;
            r_idx  <= 1'b0;
        end else if (w_ld_orphan) begin
            r_y0   <= w_in_y;
            r_cb   <= w_in_c;
            r_cr   <= NEUTRAL_CHROMA;
            r_user <= s_axis_video.tuser;
            r_last <= 1'b1;
            r_cnt  <= 2'd1;
            r_idx  <= 1'b0;
        end else if (w_m_acc) begin
            r_cnt  <= r_cnt - 2'd1;
            r_idx  <= 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_s_acc && (r_par == PAR_ODD) && s_axis_video.tuser;
        end
    end

    always_comb begin
        s_axis_video.tready = w_tready;
        m_axis_video.tvalid = (r_cnt != 2'd0);
        m_axis_video.tdata  = {r_cr, r_cb, (r_idx ? r_y1 : r_y0)};
        m_axis_video.tuser  = r_user && !r_idx;
        m_axis_video.tlast  = r_last && (r_cnt == 2'd1);
        sync_err            = r_sync_err;
    end

endmodule

// File: tb/tb_c_rsample_up.sv
// Bench for c_rsample_up: directed steps plus random traffic, checked against a
// pixel-pair reference model built from queues.
module tb_c_rsample_up;

    localparam logic [7:0] NEUTRAL = 8'h80;

    logic aclk    = 1'b0;
    logic aresetn = 1'b1;
    logic sync_err;

    c_rsample_up_if #(.W(16)) s_if ();
    c_rsample_up_if #(.W(24)) m_if ();

    c_rsample_up #(.NEUTRAL_CHROMA(NEUTRAL)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axis_video (s_if),
        .m_axis_video (m_if),
        .sync_err     (sync_err)
    );

    always #5 aclk = ~aclk;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned acc_cyc  = 0;

    // reference model state
    logic [25:0] exp_q[$];
    logic        held_v = 1'b0;
    logic [15:0] held_d = '0;
    logic        held_u = 1'b0;
    logic        exp_serr = 1'b0;

    logic [25:0] out_log[$];
    int unsigned fire_cyc[$];
    logic        got        = 1'b0;
    logic        stall_prev = 1'b0;
    logic [25:0] prev_out   = '0;
    logic        rdy_always = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // pairing rule: beat with tuser restarts pairing; odd beat completes held pixel;
    // even beat with tlast is emitted alone with neutral Cr
    task automatic model_accept(input logic [15:0] d, input logic u, input logic l);
        if (u && held_v) begin
            exp_serr = 1'b1;
            held_v   = 1'b0;
        end
        if (!held_v) begin
            if (l) begin
                exp_q.push_back({1'b1, u, NEUTRAL, d[15:8], d[7:0]});
            end else begin
                held_v = 1'b1;
                held_d = d;
                held_u = u;
            end
        end else begin
            exp_q.push_back({1'b0, held_u, d[15:8], held_d[15:8], held_d[7:0]});
            exp_q.push_back({l, 1'b0, d[15:8], held_d[15:8], d[7:0]});
            held_v = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        held_v     = 1'b0;
        exp_serr   = 1'b0;
        stall_prev = 1'b0;
    endtask

    task automatic tick();
        logic [25:0] cur;
        @(negedge aclk);
        cyc++;
        cur = {m_if.tlast, m_if.tuser, m_if.tdata};
        chk("m_tvalid", 32'(m_if.tvalid), 32'(exp_q.size() != 0));
        chk("sync_err", 32'(sync_err), 32'(exp_serr));
        if (stall_prev) chk("stall_hold", 32'(cur), 32'(prev_out));
        if (rdy_always) chk("s_tready_hi", 32'(s_if.tready), 32'(1));
        if (m_if.tvalid && m_if.tready && exp_q.size() != 0) begin
            chk("m_beat", 32'(cur), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            out_log.push_back(cur);
            fire_cyc.push_back(cyc);
        end
        got      = s_if.tvalid && s_if.tready;
        exp_serr = 1'b0;
        if (got) begin
            acc_cyc = cyc;
            model_accept(s_if.tdata, s_if.tuser, s_if.tlast);
        end
        stall_prev = m_if.tvalid && !m_if.tready;
        prev_out   = cur;
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic u, input logic l);
        int unsigned n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        got = 1'b0;
        while (!got && n < 100) begin
            tick();
            n++;
        end
        if (!got) chk("send_timeout", 32'(got), 32'(1));
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
        tick();
    endtask

    task automatic do_reset();
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        #1 aresetn = 1'b0;
        #1;
        chk("rst_m_tvalid", 32'(m_if.tvalid), 32'(0));
        chk("rst_m_tdata", 32'(m_if.tdata), 32'(0));
        chk("rst_m_tuser", 32'(m_if.tuser), 32'(0));
        chk("rst_m_tlast", 32'(m_if.tlast), 32'(0));
        chk("rst_s_tready", 32'(s_if.tready), 32'(0));
        chk("rst_sync_err", 32'(sync_err), 32'(0));
        model_reset();
        @(negedge aclk);
        #2 aresetn = 1'b1;
        @(posedge aclk);
        #1 chk("rst_rdy_edge1", 32'(s_if.tready), 32'(0));
        @(posedge aclk);
        #1 chk("rst_rdy_edge2", 32'(s_if.tready), 32'(1));
    endtask

    initial begin
        int unsigned a1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;

        // reset state and synchronised release
        do_reset();

        // basic pair with frame start and line end
        out_log.delete();
        fire_cyc.delete();
        send(16'h4010, 1'b1, 1'b0);
        send(16'hC020, 1'b0, 1'b1);
        a1 = acc_cyc;
        drain();
        chk("t1_beat0", 32'(out_log[0]), 32'({2'b01, 24'hC04010}));
        chk("t1_beat1", 32'(out_log[1]), 32'({2'b10, 24'hC04020}));
        chk("t1_latency", fire_cyc[0], a1 + 1);

        // 8-pixel line at full rate
        out_log.delete();
        fire_cyc.delete();
        rdy_always = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            send({8'(8'h20 + i), 8'(i)}, (i == 0), (i == 7));
            if (i == 1) a1 = acc_cyc;
        end
        for (int unsigned i = 0; i < 3; i++) tick();
        rdy_always = 1'b0;
        chk("t2_count", 32'(out_log.size()), 32'(8));
        chk("t2_first", fire_cyc[0], a1 + 1);
        for (int unsigned i = 1; i < 8; i++) chk("t2_consec", fire_cyc[i] - fire_cyc[0], i);

        // odd-width line ends on an orphan even pixel
        out_log.delete();
        send(16'h1101, 1'b0, 1'b0);
        send(16'h2202, 1'b0, 1'b0);
        send(16'h3303, 1'b0, 1'b1);
        drain();
        chk("t3_beat0", 32'(out_log[0]), 32'({2'b00, 24'h221101}));
        chk("t3_beat1", 32'(out_log[1]), 32'({2'b00, 24'h221102}));
        chk("t3_beat2", 32'(out_log[2]), 32'({2'b10, 24'h803303}));

        // downstream stall mid-pair
        out_log.delete();
        m_if.tready = 1'b0;
        send(16'h5501, 1'b0, 1'b0);
        send(16'h6602, 1'b0, 1'b0);
        send(16'h7703, 1'b0, 1'b0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 16'h8804;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            chk("t4_s_tready_lo", 32'(s_if.tready), 32'(0));
        end
        m_if.tready = 1'b1;
        send(16'h8804, 1'b0, 1'b1);
        drain();
        chk("t4_count", 32'(out_log.size()), 32'(4));
        chk("t4_beat0", 32'(out_log[0]), 32'({2'b00, 24'h665501}));
        chk("t4_beat1", 32'(out_log[1]), 32'({2'b00, 24'h665502}));
        chk("t4_beat3", 32'(out_log[3]), 32'({2'b10, 24'h887704}));

        // tuser while an even pixel is held
        out_log.delete();
        send(16'h12A1, 1'b0, 1'b0);
        send(16'h34B2, 1'b1, 1'b0);
        chk("t5_serr_pulse", 32'(sync_err), 32'(1));
        tick();
        chk("t5_serr_clear", 32'(sync_err), 32'(0));
        send(16'h56C3, 1'b0, 1'b1);
        drain();
        chk("t5_count", 32'(out_log.size()), 32'(2));
        chk("t5_beat0", 32'(out_log[0]), 32'({2'b01, 24'h5634B2}));
        chk("t5_beat1", 32'(out_log[1]), 32'({2'b10, 24'h5634C3}));

        // asynchronous reset with one beat still pending
        send(16'hAA11, 1'b0, 1'b0);
        send(16'hBB22, 1'b0, 1'b1);
        tick();
        m_if.tready = 1'b0;
        #2;
        chk("t6_pending", 32'(m_if.tvalid), 32'(1));
        do_reset();
        m_if.tready = 1'b1;
        out_log.delete();
        send(16'h9A01, 1'b1, 1'b0);
        send(16'hBC02, 1'b0, 1'b1);
        drain();
        chk("t6_first", 32'(out_log[0]), 32'({2'b01, 24'hBC9A01}));

        // random traffic with random backpressure
        got = 1'b0;
        for (int unsigned i = 0; i < 800; i++) begin
            if (!s_if.tvalid || got) begin
                s_if.tvalid = ($urandom_range(0, 4) != 0);
                s_if.tdata  = 16'($urandom);
                s_if.tuser  = ($urandom_range(0, 15) == 0);
                s_if.tlast  = ($urandom_range(0, 5) == 0);
            end
            m_if.tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        s_if.tvalid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
